// File: rtl/call_stack.sv
// call_stack: parametrised return-address stack for the PC unit.
// Ports: clk, rst (async active-low), push/pop/stack_in commands,
//   tos_we/tos_wdata top-of-stack write, flag_clr sticky clear;
//   outputs stack_out, level, full, empty, ovf, unf.
module call_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] stack_in,
  input  logic             tos_we,
  input  logic [WIDTH-1:0] tos_wdata,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] stack_out,
  output logic [PW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PW:0] LV_MAX = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_level;
  logic             r_ovf;
  logic             r_unf;

  logic             w_full;
  logic             w_empty;
  logic             w_rep;
  logic             w_push;
  logic             w_pop;
  logic             w_tos;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [PW-1:0]    w_ptr_inc;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW:0]      w_lvl_nxt;
  logic             w_we;
  logic [PW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  assign w_full  = (r_level == LV_MAX);
  assign w_empty = (r_level == '0);

  // push+pop on an empty stack degrades to a plain push
  assign w_rep  = push & pop & ~w_empty;
  assign w_push = push & (~pop | w_empty);
  assign w_pop  = pop & ~push;
  assign w_tos  = tos_we & ~push & ~pop & ~w_empty;

  assign w_ovf_set = w_push & w_full;
  assign w_unf_set = w_pop & w_empty;

  assign w_ptr_inc = r_ptr + 1'b1;

  always_comb begin
    w_ptr_nxt = r_ptr;
    w_lvl_nxt = r_level;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_wdata   = stack_in;
    unique case (1'b1)
      w_rep: begin
        w_we = 1'b1;
      end
      w_push: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_waddr   = w_ptr_inc;
          w_ptr_nxt = w_ptr_inc;
          w_lvl_nxt = r_level + 1'b1;
        end else if (WRAP) begin
          // slot above top is the oldest entry when full
          w_we      = 1'b1;
          w_waddr   = w_ptr_inc;
          w_ptr_nxt = w_ptr_inc;
        end
      end
      w_pop: begin
        if (!w_empty) begin
          w_ptr_nxt = r_ptr - 1'b1;
          w_lvl_nxt = r_level - 1'b1;
        end
      end
      w_tos: begin
        w_we    = 1'b1;
        w_wdata = tos_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '1;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_level <= w_lvl_nxt;
      r_ovf   <= (r_ovf & ~flag_clr) | w_ovf_set;
      r_unf   <= (r_unf & ~flag_clr) | w_unf_set;
    end
  end

  // storage is never reset; contents are masked while empty
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign stack_out = w_empty ? '0 : r_mem[r_ptr];
  assign level     = r_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: randomized and directed bench for call_stack,
// WRAP=0 and WRAP=1 instances against a queue-based model.
module tb_call_stack;

  typedef logic [10:0] q_t [$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [10:0] stack_in = '0;
  logic        tos_we = 1'b0;
  logic [10:0] tos_wdata = '0;
  logic        flag_clr = 1'b0;

  logic [10:0] so0, so1;
  logic [4:0]  lv0, lv1;
  logic        fu0, fu1, em0, em1, ov0, ov1, un0, un1;

  int vectors = 0;
  int miscompares = 0;

  q_t mq0, mq1;
  bit mo0, mo1, mu0, mu1;

  logic [19:0] ob [2];
  logic [19:0] ex;

  always #5 clk = ~clk;

  call_stack #(.WIDTH(11), .DEPTH(16), .WRAP(1'b0)) u0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .stack_in(stack_in), .tos_we(tos_we), .tos_wdata(tos_wdata),
    .flag_clr(flag_clr), .stack_out(so0), .level(lv0),
    .full(fu0), .empty(em0), .ovf(ov0), .unf(un0)
  );

  call_stack #(.WIDTH(11), .DEPTH(16), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .stack_in(stack_in), .tos_we(tos_we), .tos_wdata(tos_wdata),
    .flag_clr(flag_clr), .stack_out(so1), .level(lv1),
    .full(fu1), .empty(em1), .ovf(ov1), .unf(un1)
  );

  assign ob[0] = {so0, lv0, fu0, em0, ov0, un0};
  assign ob[1] = {so1, lv1, fu1, em1, ov1, un1};

  function automatic void mstep(inout q_t q, inout bit ov,
                                inout bit un, input bit wrap,
                                input bit p, input bit po,
                                input bit tw, input bit fc,
                                input logic [10:0] d,
                                input logic [10:0] twd);
    int n;
    n = q.size();
    if (fc) begin
      ov = 1'b0;
      un = 1'b0;
    end
    if (p && po && n > 0) begin
      q[n-1] = d;
    end else if (p) begin
      if (n < 16) q.push_back(d);
      else begin
        ov = 1'b1;
        if (wrap) begin
          void'(q.pop_front());
          q.push_back(d);
        end
      end
    end else if (po) begin
      if (n > 0) void'(q.pop_back());
      else un = 1'b1;
    end else if (tw && n > 0) begin
      q[n-1] = twd;
    end
  endfunction

  function automatic logic [19:0] expv(q_t q, bit ov, bit un);
    int n;
    logic [10:0] t;
    n = q.size();
    t = (n > 0) ? q[n-1] : 11'h0;
    return {t, 5'(n), n == 16, n == 0, ov, un};
  endfunction

  function automatic logic [19:0] exp_of(int k);
    return k ? expv(mq1, mo1, mu1) : expv(mq0, mo0, mu0);
  endfunction

  task automatic cyc(bit p, bit po, logic [10:0] d,
                     bit tw, logic [10:0] twd, bit fc);
    push = p; pop = po; stack_in = d;
    tos_we = tw; tos_wdata = twd; flag_clr = fc;
    @(posedge clk);
    mstep(mq0, mo0, mu0, 1'b0, p, po, tw, fc, d, twd);
    mstep(mq1, mo1, mu1, 1'b1, p, po, tw, fc, d, twd);
    #1;
    push = 0; pop = 0; tos_we = 0; flag_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq0.delete(); mq1.delete();
    mo0 = 0; mo1 = 0; mu0 = 0; mu1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ob[k] !== {11'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset dut%0d got %h exp %h", k, ob[k],
                 {11'h0, 5'd0, 4'b0100});
      end
    end
  endtask

  task automatic test_basic();
    logic [10:0] want [3];
    want[0] = 11'h456; want[1] = 11'h123; want[2] = 11'h000;
    do_reset();
    cyc(1, 0, 11'h123, 0, 0, 0);
    cyc(1, 0, 11'h456, 0, 0, 0);
    cyc(1, 0, 11'h789, 0, 0, 0);
    vectors++;
    if ({so0, lv0} !== {11'h789, 5'd3}) begin
      miscompares++;
      $display("FAIL basic_top got %h/%0d exp 789/3", so0, lv0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      vectors++;
      if (so0 !== want[i]) begin
        miscompares++;
        $display("FAIL basic_pop%0d got %h exp %h", i, so0, want[i]);
      end
    end
    vectors++;
    if ({em0, un0} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_empty got e=%b u=%b exp e=1 u=0", em0, un0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 11'(i), 0, 0, 0);
    vectors++;
    if ({fu0, fu1} !== 2'b11) begin
      miscompares++;
      $display("FAIL ovf_full got %b%b exp 11", fu0, fu1);
    end
    cyc(1, 0, 11'h7FF, 0, 0, 0);
    vectors++;
    if ({so0, lv0, ov0} !== {11'h00F, 5'd16, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_drop got %h/%0d/%b exp 00f/16/1",
               so0, lv0, ov0);
    end
    vectors++;
    if ({so1, lv1, ov1} !== {11'h7FF, 5'd16, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_wrap got %h/%0d/%b exp 7ff/16/1",
               so1, lv1, ov1);
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        ex = exp_of(k);
        vectors++;
        if (ob[k] !== ex) begin
          miscompares++;
          $display("FAIL ovf_pop%0d dut%0d got %h exp %h",
                   i, k, ob[k], ex);
        end
      end
      cyc(0, 1, 0, 0, 0, 0);
    end
    vectors++;
    if ({em0, em1} !== 2'b11) begin
      miscompares++;
      $display("FAIL ovf_drain got %b%b exp 11", em0, em1);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    vectors++;
    if ({un0, lv0} !== {1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL unf_set got %b/%0d exp 1/0", un0, lv0);
    end
    cyc(0, 1, 0, 0, 0, 1);
    vectors++;
    if (un0 !== 1'b1) begin
      miscompares++;
      $display("FAIL unf_setwins got %b exp 1", un0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    vectors++;
    if (un0 !== 1'b0) begin
      miscompares++;
      $display("FAIL unf_clr got %b exp 0", un0);
    end
  endtask

  task automatic test_replace_tos();
    do_reset();
    cyc(1, 0, 11'h100, 0, 0, 0);
    cyc(1, 0, 11'h200, 0, 0, 0);
    cyc(1, 1, 11'h333, 0, 0, 0);
    vectors++;
    if ({so0, lv0} !== {11'h333, 5'd2}) begin
      miscompares++;
      $display("FAIL replace got %h/%0d exp 333/2", so0, lv0);
    end
    cyc(0, 0, 0, 1, 11'h044, 0);
    vectors++;
    if (so0 !== 11'h044) begin
      miscompares++;
      $display("FAIL tos_we got %h exp 044", so0);
    end
    cyc(1, 0, 11'h055, 1, 11'h066, 0);
    vectors++;
    if ({so0, lv0} !== {11'h055, 5'd3}) begin
      miscompares++;
      $display("FAIL tos_ign got %h/%0d exp 055/3", so0, lv0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    vectors++;
    if (so0 !== 11'h044) begin
      miscompares++;
      $display("FAIL tos_below got %h exp 044", so0);
    end
  endtask

  task automatic test_random();
    int pp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // alternate push-heavy and pop-heavy phases to visit both ends
      pp = ((i / 50) % 2) ? 25 : 70;
      cyc($urandom_range(0, 99) < pp,
          $urandom_range(0, 99) >= pp,
          11'($urandom), $urandom_range(0, 3) == 0,
          11'($urandom), $urandom_range(0, 15) == 0);
      for (int k = 0; k < 2; k++) begin
        ex = exp_of(k);
        vectors++;
        if (ob[k] !== ex) begin
          miscompares++;
          $display("FAIL rand%0d dut%0d got %h exp %h",
                   i, k, ob[k], ex);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 11'(i + 1), 0, 0, 0);
    vectors++;
    if (lv0 !== 5'd5) begin
      miscompares++;
      $display("FAIL arst_pre got %0d exp 5", lv0);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ob[k] !== {11'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL arst dut%0d got %h exp %h", k, ob[k],
                 {11'h0, 5'd0, 4'b0100});
      end
    end
    do_reset();
    cyc(1, 0, 11'h2AA, 0, 0, 0);
    vectors++;
    if ({so0, lv0} !== {11'h2AA, 5'd1}) begin
      miscompares++;
      $display("FAIL arst_post got %h/%0d exp 2aa/1", so0, lv0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_replace_tos();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the PIC16F1826 core, successor to the fixed 16×11 stack. Holds CALL/interrupt return addresses. Adds configurable width/depth, overflow policy, sticky STKOVF/STKUNF flags, same-cycle replace, a TOS write port, and an occupancy count for the SFR view. Sits beside the PC unit: push on CALL/interrupt entry, pop on RETURN/RETFIE/RETLW.

## Interface
- WIDTH, 11: entry width (PC bits).
- DEPTH, 16: entries; power of two, ≥ 2. PW = clog2(DEPTH).
- WRAP, 0: 1 = push when full overwrites oldest entry; 0 = push when full is dropped.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  push stack_in this cycle.
- pop  in  1  pop top this cycle.
- stack_in  in  WIDTH  return address to push.
- tos_we  in  1  overwrite top entry with tos_wdata.
- tos_wdata  in  WIDTH  TOS write data.
- flag_clr  in  1  clear sticky ovf/unf.
- stack_out  out  WIDTH  current top entry; 0 when empty.
- level  out  PW+1  entries held, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

## Operation
- State: storage array mem[DEPTH] (not reset), top pointer ptr (PW bits), level, ovf, unf.
- Reset (rst low, async): ptr = all ones, level = 0, ovf = unf = 0. Outputs: stack_out = 0, level = 0, empty = 1, full = 0, ovf = unf = 0.
- Per-cycle command, evaluated in priority order:
  - push & pop:
    - If not empty: replace. mem[ptr] <= stack_in; ptr and level unchanged; no flags.
    - If empty: plain push.
  - push only:
    - level < DEPTH: mem[ptr+1] <= stack_in; ptr++ (mod DEPTH); level++.
    - Full, WRAP=1: write and ptr++ as above (oldest overwritten); level stays DEPTH; ovf <= 1.
    - Full, WRAP=0: no write, no pointer change; ovf <= 1.
  - pop only:
    - level > 0: ptr-- (mod DEPTH); level--.
    - Empty: no change; unf <= 1.
  - tos_we only (no push/pop): if not empty, mem[ptr] <= tos_wdata; ignored when empty. tos_we is ignored whenever push or pop is asserted.
  - idle: hold.
- flag_clr clears ovf and unf. A set event in the same cycle wins (flag ends 1).
- stack_out = empty ? 0 : mem[ptr]. Combinational from registered state; no input-to-output path.
- full and empty are decoded from level.
- Pointer arithmetic is PW bits with natural wrap. level is PW+1 bits and never exceeds DEPTH.

## Timing
- Single clock domain. All state updates on the rising clk edge, except asynchronous reset assertion.
- Push, pop, replace and TOS write latency: 1 cycle. New top/level visible after the edge.
- Back-to-back commands every cycle are supported; no stall or handshake.
- Pop followed by push next cycle reuses the slot just freed.
- Reset asserted mid-operation:
  - Immediately forces the reset values of ptr, level and flags.
  - mem contents are undefined-but-harmless; they are never visible while empty.
- Reset release must be synchronised to clk at system level.

## Test plan
- Reset, push 0x123, 0x456, 0x789 on consecutive cycles:
  - stack_out 0x789, level 3.
  - Three pops → 0x456, 0x123, then 0 with empty=1, unf=0.
- WRAP=0, DEPTH=16: push 0x000..0x00F → full=1. Push 0x7FF → stack_out 0x00F, level 16, ovf=1.
  - Then 16 pops return 0x00F..0x000.
- WRAP=1, same fill then push 0x7FF:
  - stack_out 0x7FF, level 16, ovf=1.
  - 16 pops return 0x7FF, 0x00F..0x001 (0x000 lost).
- Empty pop: unf=1, level 0. flag_clr with simultaneous empty pop → unf stays 1. Next-cycle flag_clr alone → unf=0.
- Push 0x100, 0x200, then push+pop with 0x333:
  - stack_out 0x333, level 2.
  - tos_we 0x044 → stack_out 0x044.
  - tos_we with push 0x055 → stack_out 0x055, level 3 (tos_we ignored).
- Push 5 entries, assert rst low between clock edges: outputs reset immediately (level 0, stack_out 0, empty=1) without waiting for a clock edge.
